// File: rtl/mem_bus_bridge_if.sv
// mem_bus_bridge_if: valid/ready data-RAM bus between the bridge (master) and the RAM (slave)
interface mem_bus_bridge_if #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int WordSize  = 4
);
    logic                 bus_valid;
    logic                 bus_write;
    logic [AddrWidth-1:0] bus_address;
    logic [DataWidth-1:0] bus_write_data;
    logic [WordSize-1:0]  bus_write_strobe;
    logic                 bus_ready;
    logic [DataWidth-1:0] bus_read_data;

    modport master (
        output bus_valid, bus_write, bus_address, bus_write_data, bus_write_strobe,
        input  bus_ready, bus_read_data
    );

    modport slave (
        input  bus_valid, bus_write, bus_address, bus_write_data, bus_write_strobe,
        output bus_ready, bus_read_data
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: multi-cycle data-memory bus master; MEM_BUS_BRIDGE_TIMEOUT_EN adds a bus_ready timeout with fault pulse
module mem_bus_bridge #(
    parameter int DataWidth     = 32,
    parameter int AddrWidth     = 32,
    parameter int WordSize      = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_req_read,
    input  logic                 i_req_write,
    input  logic [AddrWidth-1:0] i_req_address,
    input  logic [DataWidth-1:0] i_req_write_data,
    input  logic [WordSize-1:0]  i_req_write_strobe,
    output logic [DataWidth-1:0] o_req_read_data,
    output logic                 o_stall,
    output logic                 o_fault,
    mem_bus_bridge_if.master     bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               r_state;
    logic                 r_valid;
    logic                 r_write;
    logic [AddrWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [WordSize-1:0]  r_strobe;
    logic [DataWidth-1:0] r_rdata;
    logic                 w_start;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    localparam int CntRaw = $clog2(TimeoutCycles + 1);
    localparam int CntW   = CntRaw < 8 ? 8 : (CntRaw > 32 ? 32 : CntRaw);
    logic [CntW-1:0] r_cnt;
    logic            r_fault;
    assign o_fault = r_fault;
`else
    assign o_fault = 1'b0;
`endif

    assign w_start              = i_req_read || (i_req_write && |i_req_write_strobe);
    assign o_stall              = (i_req_read || i_req_write) && r_state != DONE;
    assign o_req_read_data      = r_rdata;
    assign bus.bus_valid        = r_valid;
    assign bus.bus_write        = r_write;
    assign bus.bus_address      = r_addr;
    assign bus.bus_write_data   = r_wdata;
    assign bus.bus_write_strobe = r_strobe;

    // Transaction FSM: latch request in IDLE, hold the bus in BUSY until ready (or timeout), one-cycle DONE releases the stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_write  <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_strobe <= '0;
            r_rdata  <= '0;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
            r_cnt    <= '0;
            r_fault  <= 1'b0;
`endif
        end else begin
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
            r_fault <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_valid  <= 1'b1;
                        r_write  <= i_req_write && !i_req_read;
                        r_addr   <= i_req_address & ~AddrWidth'(3);
                        r_wdata  <= i_req_write_data;
                        r_strobe <= i_req_read ? '0 : i_req_write_strobe;
                        r_state  <= BUSY;
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
                        r_cnt    <= '0;
`endif
                    end else if (i_req_write) begin
                        r_state <= DONE;
                    end
                end
                BUSY: begin
                    if (bus.bus_ready) begin
                        r_valid <= 1'b0;
                        if (!r_write) r_rdata <= bus.bus_read_data;
                        r_state <= DONE;
                    end
`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
                    else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
                        r_valid <= 1'b0;
                        if (!r_write) r_rdata <= '0;
                        r_fault <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_bridge.sv
// tb_mem_bus_bridge: directed plus randomized transactions checked against a transaction-level model of the bridge
module tb_mem_bus_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_address = '0;
    logic [31:0] req_write_data = '0;
    logic [3:0]  req_write_strobe = '0;
    logic [31:0] req_read_data;
    logic        stall;
    logic        fault;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_rdata = '0;

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int KMAX = 3;
`else
    localparam int TO   = 255;
    localparam int KMAX = 5;
`endif

    always #5 clk = ~clk;

    mem_bus_bridge_if #(.DataWidth(32), .AddrWidth(32), .WordSize(4)) bus_if ();

    mem_bus_bridge #(.DataWidth(32), .AddrWidth(32), .WordSize(4), .TimeoutCycles(TO)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_req_read         (req_read),
        .i_req_write        (req_write),
        .i_req_address      (req_address),
        .i_req_write_data   (req_write_data),
        .i_req_write_strobe (req_write_strobe),
        .o_req_read_data    (req_read_data),
        .o_stall            (stall),
        .o_fault            (fault),
        .bus                (bus_if.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One pipeline request held until the stall drops; k = bus_valid cycle on which the slave answers (0 = never)
    task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int k);
        bit          noop = wr && !rd && strb == 4'b0000;
        bit          ew = wr && !rd;
        logic [3:0]  es = ew ? strb : 4'b0000;
        logic [31:0] ea = addr - (addr % 4);
        logic [31:0] word = $urandom;
        int          sc = 0;
        int          vc = 0;
        bit          done = 0;
        req_read = rd;
        req_write = wr;
        req_address = addr;
        req_write_data = data;
        req_write_strobe = strb;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (!stall) done = 1;
            else begin
                sc++;
                if (bus_if.bus_valid) begin
                    vc++;
                    chk("bus_address", bus_if.bus_address, ea);
                    chk("bus_write", {31'b0, bus_if.bus_write}, {31'b0, ew});
                    chk("bus_strobe", {28'b0, bus_if.bus_write_strobe}, {28'b0, es});
                    if (ew) chk("bus_wdata", bus_if.bus_write_data, data);
                    req_address = $urandom;
                    req_write_data = $urandom;
                    req_write_strobe = 4'($urandom);
                    bus_if.bus_ready = (vc == k);
                    bus_if.bus_read_data = (vc == k) ? word : $urandom;
                end else begin
                    bus_if.bus_ready = 1'($urandom);
                    bus_if.bus_read_data = $urandom;
                end
                @(posedge clk);
                @(negedge clk);
            end
        end
        chk("stall_bound", {31'b0, done}, 32'd1);
        if (rd) exp_rdata = (k == 0) ? 32'h0 : word;
        chk("stall_cycles", sc, noop ? 1 : (k == 0 ? TO + 1 : k + 1));
        chk("valid_cycles", vc, noop ? 0 : (k == 0 ? TO : k));
        chk("read_data", req_read_data, exp_rdata);
        chk("fault", {31'b0, fault}, {31'b0, (k == 0 && !noop)});
        chk("done_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        bus_if.bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("idle_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("idle_fault", {31'b0, fault}, 32'd0);
    endtask

    task automatic idle(input int n);
        req_read = 1'b0;
        req_write = 1'b0;
        bus_if.bus_ready = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("gap_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("gap_stall", {31'b0, stall}, 32'd0);
        bus_if.bus_ready = 1'b0;
    endtask

    initial begin
        bus_if.bus_ready = 1'b0;
        bus_if.bus_read_data = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("rst_write", {31'b0, bus_if.bus_write}, 32'd0);
        chk("rst_addr", bus_if.bus_address, 32'd0);
        chk("rst_wdata", bus_if.bus_write_data, 32'd0);
        chk("rst_strobe", {28'b0, bus_if.bus_write_strobe}, 32'd0);
        chk("rst_rdata", req_read_data, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        run(1'b1, 1'b0, 32'h0000_1006, 32'h0, 4'b0000, 1);
        run(1'b0, 1'b1, 32'h0000_2000, 32'h1234_0000, 4'b1100, 3);
        run(1'b0, 1'b1, 32'h0000_3000, 32'hFFFF_FFFF, 4'b0000, 1);
        run(1'b1, 1'b1, 32'h0000_4003, 32'hAAAA_5555, 4'b0000, 2);
        run(1'b0, 1'b1, 32'h0000_5001, 32'h0BAD_F00D, 4'b0011, 1);
        idle(2);

        req_read = 1'b1;
        req_address = 32'h0000_0040;
        bus_if.bus_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("busy_valid", {31'b0, bus_if.bus_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        exp_rdata = '0;
        chk("midrst_valid", {31'b0, bus_if.bus_valid}, 32'd0);
        chk("midrst_rdata", req_read_data, exp_rdata);
        chk("midrst_addr", bus_if.bus_address, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

`ifdef MEM_BUS_BRIDGE_TIMEOUT_EN
        run(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 1);
        run(1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'b0000, 0);
        run(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 4);
        run(1'b0, 1'b1, 32'h0000_0400, 32'h5A5A_5A5A, 4'b1111, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            int          t = $urandom_range(0, 3);
            logic [3:0]  s = 4'($urandom);
            if (t == 1 && s == 4'b0000) s = 4'b0001;
            if (t == 2) s = 4'b0000;
            run(t == 0 || t == 3, t != 0, $urandom, $urandom, s, $urandom_range(1, KMAX));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
